// File: rtl/rr_requester_if.sv
// Client-side bundle of the rr_if protocol: per-client valid/ready/data inputs,
// request/grant exchange with the arbiter, and the single-entry output stage.
interface rr_requester_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;
  logic [N-1:0]   starve_err;

  // The requester block itself.
  modport slave (
    input  in_valid, in_data, grant, out_ready,
    output in_ready, req, out_valid, out_data, out_id, starve_err
  );

  // Clients, arbiter and downstream consumer seen as one environment.
  modport master (
    output in_valid, in_data, grant, out_ready,
    input  in_ready, req, out_valid, out_data, out_id, starve_err
  );
endinterface

// File: rtl/rr_requester.sv
// Round-robin arbiter front end: one holding register per client, request
// generation, grant consumption into a registered output stage, starvation flags.
module rr_requester #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  rr_requester_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, BUSY} out_state_e;

  out_state_e    state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [W-1:0]  hold_q [N];
  logic [W-1:0]  hold_d [N];
  logic [CW-1:0] wait_q [N];
  logic [CW-1:0] wait_d [N];
  logic [N-1:0]  starve_q, starve_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [IW-1:0] out_id_q, out_id_d;

  logic [N-1:0]  hit;
  logic [IW-1:0] take_idx;
  logic          free;
  logic          take;

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    pending_d  = pending_q;
    hold_d     = hold_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;

    // Only a grant to a pending client counts; a multi-hot grant resolves to its lowest pending bit.
    hit      = bus.grant & pending_q;
    take_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) take_idx = IW'(i);
    end
    free = (state_q == IDLE) || bus.out_ready;
    take = (|hit) && free;

    for (int i = 0; i < N; i++) begin
      if (take && (take_idx == IW'(i))) begin
        pending_d[i] = 1'b0;
        wait_d[i]    = '0;
      end else if (!pending_q[i]) begin
        wait_d[i] = '0;
        if (bus.in_valid[i]) begin
          pending_d[i] = 1'b1;
          hold_d[i]    = bus.in_data[i*W +: W];
        end
      end else begin
        if (wait_q[i] != CW'(MAX_WAIT)) wait_d[i] = wait_q[i] + CW'(1);
        if (wait_d[i] == CW'(MAX_WAIT)) starve_d[i] = 1'b1;
      end
    end

    // A take while draining keeps the stage BUSY with the new payload, so no bubble.
    if (take) begin
      state_d    = BUSY;
      out_data_d = hold_q[take_idx];
      out_id_d   = take_idx;
    end else if (bus.out_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      starve_q   <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
      for (int i = 0; i < N; i++) wait_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      starve_q   <= starve_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      wait_q     <= wait_d;
    end
  end

  // NOTE: payload registers are deliberately unreset; they are only read while pending is set.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign bus.in_ready   = ~pending_q;
  assign bus.req        = pending_q;
  assign bus.out_valid  = (state_q == BUSY);
  assign bus.out_data   = out_data_q;
  assign bus.out_id     = out_id_q;
  assign bus.starve_err = starve_q;
endmodule

// File: tb/tb_rr_requester.sv
// Bench for rr_requester: behavioural arbiter and client model, scoreboard of taken
// transactions, directed scenarios followed by randomized traffic.
module tb_rr_requester;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_WAIT = 4;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_requester_if #(.N(N), .W(W)) bus ();

  rr_requester #(.N(N), .W(W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arbiter stand-in: registered round-robin grant, or a bench-forced value.
  bit           force_en;
  logic [N-1:0] force_val;
  int           rr_ptr;
  always @(posedge clk) begin
    logic [N-1:0] g;
    bit           found;
    if (reset) begin
      bus.grant <= '0;
      rr_ptr = 0;
    end else if (force_en) begin
      bus.grant <= force_val;
    end else begin
      g = '0;
      found = 0;
      for (int j = 0; j < N; j++) begin
        if (!found && bus.req[(rr_ptr + j) % N]) begin
          g[(rr_ptr + j) % N] = 1'b1;
          found = 1;
          rr_ptr = (rr_ptr + j + 1) % N;
        end
      end
      bus.grant <= g;
    end
  end

  // Reference model: what each client holds, how long it has waited, and what the
  // output stage must present next; taken transactions go to the scoreboard queue.
  logic [N-1:0] pend_m = '0;
  logic [N-1:0] starve_m = '0;
  bit           ov_m = 0;
  logic [W-1:0] val_m [N];
  int           wait_m [N];
  item_t        exp_q [$];
  always @(posedge clk) begin
    logic [N-1:0] was_pending;
    int           k;
    if (reset) begin
      pend_m   = '0;
      starve_m = '0;
      ov_m     = 0;
      for (int i = 0; i < N; i++) wait_m[i] = 0;
      exp_q.delete();
    end else begin
      was_pending = pend_m;
      k = -1;
      if (!ov_m || bus.out_ready) begin
        for (int i = N - 1; i >= 0; i--) if (bus.grant[i] && pend_m[i]) k = i;
      end
      for (int i = 0; i < N; i++) begin
        if (pend_m[i] && i != k) begin
          if (wait_m[i] < MAX_WAIT) wait_m[i]++;
          if (wait_m[i] == MAX_WAIT) starve_m[i] = 1'b1;
        end else begin
          wait_m[i] = 0;
        end
      end
      if (k >= 0) begin
        exp_q.push_back('{id: k, data: val_m[k]});
        pend_m[k] = 1'b0;
        ov_m = 1;
      end else if (bus.out_ready) begin
        ov_m = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.in_valid[i] && !was_pending[i]) begin
          pend_m[i] = 1'b1;
          val_m[i]  = bus.in_data[i*W +: W];
        end
      end
    end
  end

  // Monitor: compares the DUT against the model mid-cycle and pops one scoreboard
  // entry each time a new transaction appears on the output.
  bit    prev_free = 1;
  item_t last;
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    exp_rdy = ~pend_m;
    check("req", bus.req, pend_m);
    check("in_ready", bus.in_ready, exp_rdy);
    check("starve_err", bus.starve_err, starve_m);
    check("out_valid", bus.out_valid, ov_m);
    if (bus.out_valid) begin
      if (prev_free) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: output id %0d data 0x%0h, expected no transaction", bus.out_id, bus.out_data);
        end else begin
          last = exp_q.pop_front();
          check("out_id", bus.out_id, last.id);
          check("out_data", bus.out_data, last.data);
        end
      end else begin
        check("out_id hold", bus.out_id, last.id);
        check("out_data hold", bus.out_data, last.data);
      end
    end
    prev_free = !bus.out_valid || bus.out_ready;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic v, input int id, input logic [W-1:0] d);
    check({name, " valid"}, bus.out_valid, v);
    if (v) begin
      check({name, " id"}, bus.out_id, id);
      check({name, " data"}, bus.out_data, d);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    force_en     = 0;
    force_val    = '0;
    step(2);
    reset = 1'b0;
    check("reset req", bus.req, 4'b0000);
    check("reset in_ready", bus.in_ready, 4'b1111);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_data", bus.out_data, 8'h00);
    check("reset out_id", bus.out_id, 2'd0);
    check("reset starve", bus.starve_err, 4'b0000);

    // Single uncontended transaction, including the stale-grant cycle after the take.
    bus.in_valid = 4'b0100;
    bus.in_data[2*W +: W] = 8'hA5;
    step();
    bus.in_valid = '0;
    check("single req", bus.req, 4'b0100);
    check("single in_ready", bus.in_ready, 4'b1011);
    step();
    expect_out("single t+2", 1'b0, 0, 8'h00);
    step();
    expect_out("single t+3", 1'b1, 2, 8'hA5);
    step();
    expect_out("single stale", 1'b0, 0, 8'h00);
    check("single req after", bus.req, 4'b0000);
    step();
    expect_out("single no dup", 1'b0, 0, 8'h00);

    // All four clients at once: one output per cycle in rotation order.
    do_reset();
    bus.in_valid = 4'b1111;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 8'(8'h10 + i);
    step();
    bus.in_valid = '0;
    step();
    for (int k = 0; k < N; k++) begin
      step();
      expect_out("burst", 1'b1, k, 8'(8'h10 + k));
      check("burst in_ready", bus.in_ready, (64'd1 << (k + 1)) - 64'd1);
    end
    step();
    expect_out("burst end", 1'b0, 0, 8'h00);

    // Back-pressure: first output held, second waits and follows with no bubble.
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0011;
    bus.in_data[0 +: W] = 8'h21;
    bus.in_data[W +: W] = 8'h22;
    step();
    bus.in_valid = '0;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      expect_out("stall", 1'b1, 0, 8'h21);
      check("stall req", bus.req, 4'b0010);
    end
    step();
    bus.out_ready = 1'b1;
    expect_out("release", 1'b1, 0, 8'h21);
    step();
    expect_out("no bubble", 1'b1, 1, 8'h22);
    step();
    expect_out("drained", 1'b0, 0, 8'h00);

    // Starvation with the grant held at zero; the flag is sticky until reset.
    force_en  = 1;
    force_val = '0;
    do_reset();
    bus.in_valid = 4'b1000;
    bus.in_data[3*W +: W] = 8'h5C;
    step();
    bus.in_valid = '0;
    step(3);
    check("starve before", bus.starve_err, 4'b0000);
    step();
    check("starve at MAX_WAIT", bus.starve_err, 4'b1000);
    force_en = 0;
    step(2);
    expect_out("starved taken", 1'b1, 3, 8'h5C);
    check("starve sticky", bus.starve_err, 4'b1000);
    step(2);
    check("starve still", bus.starve_err, 4'b1000);
    do_reset();
    check("starve cleared", bus.starve_err, 4'b0000);

    // Multi-hot grant: only the lowest pending client is taken.
    force_en  = 1;
    force_val = '0;
    do_reset();
    bus.in_valid = 4'b0110;
    bus.in_data[W +: W]   = 8'h31;
    bus.in_data[2*W +: W] = 8'h32;
    step();
    bus.in_valid = '0;
    force_val = 4'b0110;
    step();
    force_val = '0;
    step();
    expect_out("multihot", 1'b1, 1, 8'h31);
    check("multihot req", bus.req, 4'b0100);
    check("multihot in_ready", bus.in_ready, 4'b1011);
    step();
    expect_out("multihot single", 1'b0, 0, 8'h00);
    check("multihot req hold", bus.req, 4'b0100);

    // Reset while BUSY with two clients still pending.
    force_val = 4'b0001;
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0111;
    for (int i = 0; i < 3; i++) bus.in_data[i*W +: W] = 8'(8'h40 + i);
    step();
    bus.in_valid = '0;
    step();
    expect_out("busy", 1'b1, 0, 8'h40);
    check("busy req", bus.req, 4'b0110);
    step(4);
    do_reset();
    check("mid reset out_valid", bus.out_valid, 1'b0);
    check("mid reset req", bus.req, 4'b0000);
    check("mid reset in_ready", bus.in_ready, 4'b1111);
    check("mid reset starve", bus.starve_err, 4'b0000);
    force_en = 0;
    bus.out_ready = 1'b1;

    // Randomized traffic, back-pressure, forced (stale or multi-hot) grants, resets.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = N'($urandom);
      bus.in_data   = (N*W)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) force_en = !force_en;
      force_val = N'($urandom);
      reset = (c % 700 == 699);
      step();
    end
    reset = 1'b0;
    force_en = 0;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    step(20);
    check("scoreboard empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
